// File: rtl/mcc_pkg.sv
// Shared types and encodings for the multi-cycle controller:
// FSM states, instruction classes, ALU ops and datapath select codes.
package mcc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NOP   = 4'd0,
        C_RTYPE = 4'd1,
        C_SHIFT = 4'd2,
        C_ITYPE = 4'd3,
        C_LW    = 4'd4,
        C_SW    = 4'd5,
        C_BEQ   = 4'd6,
        C_BNE   = 4'd7,
        C_J     = 4'd8,
        C_JR    = 4'd9,
        C_JAL   = 4'd10,
        C_JALR  = 4'd11
    } cls_t;

    localparam int CLS_N = 12;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_REG   = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMS2 = 2'd3;

    localparam logic [1:0] TR_ALU = 2'd0;
    localparam logic [1:0] TR_MEM = 2'd1;
    localparam logic [1:0] TR_PC  = 2'd2;

    localparam logic [1:0] DR_RT = 2'd0;
    localparam logic [1:0] DR_RD = 2'd1;
    localparam logic [1:0] DR_RA = 2'd2;

    localparam logic [1:0] J_ALU = 2'd0;
    localparam logic [1:0] J_BR  = 2'd1;
    localparam logic [1:0] J_TGT = 2'd2;
    localparam logic [1:0] J_REG = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_NOP  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    function automatic cls_t cls_from_onehot(logic [CLS_N-1:0] oh);
        cls_t c;
        c = C_NOP;
        for (int i = 0; i < CLS_N; i++) begin
            if (oh[i]) c = cls_t'(4'(i));
        end
        return c;
    endfunction

    function automatic logic [3:0] alu_op(logic [5:0] opc, logic [5:0] fn);
        logic [3:0] op;
        op = ALU_ADD;
        if (opc == OP_RTYPE) begin
            case (fn)
                F_SUB, F_SUBU:  op = ALU_SUB;
                F_AND:          op = ALU_AND;
                F_OR:           op = ALU_OR;
                F_XOR:          op = ALU_XOR;
                F_NOR:          op = ALU_NOR;
                F_SLT:          op = ALU_SLT;
                F_SLTU:         op = ALU_SLTU;
                F_SLLV:         op = ALU_SLL;
                F_SRL, F_SRLV:  op = ALU_SRL;
                F_SRA, F_SRAV:  op = ALU_SRA;
                default:        op = ALU_ADD;
            endcase
        end else begin
            case (opc)
                OP_SLTI:  op = ALU_SLT;
                OP_SLTIU: op = ALU_SLTU;
                OP_ANDI:  op = ALU_AND;
                OP_ORI:   op = ALU_OR;
                OP_XORI:  op = ALU_XOR;
                default:  op = ALU_ADD;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/mcc_class_decoder.sv
// Combinational opcode/func -> one-hot instruction class plus illegal flag.
// Ports: opcode_i/func_i in; cls_oh_o (one bit per cls_t), illegal_o out.
// func 0x00 under opcode 0 is the canonical nop (sll r0,r0,0).
module mcc_class_decoder
    import mcc_pkg::*;
(
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       func_i,
    output logic [CLS_N-1:0] cls_oh_o,
    output logic             illegal_o
);

    always_comb begin
        cls_oh_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                case (func_i)
                    F_NOP: cls_oh_o[C_NOP] = 1'b1;
                    F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV:
                        cls_oh_o[C_SHIFT] = 1'b1;
                    F_JR:   cls_oh_o[C_JR]   = 1'b1;
                    F_JALR: cls_oh_o[C_JALR] = 1'b1;
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND,
                    F_OR, F_XOR, F_NOR, F_SLT, F_SLTU:
                        cls_oh_o[C_RTYPE] = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:
                cls_oh_o[C_ITYPE] = 1'b1;
            OP_LW:  cls_oh_o[C_LW]  = 1'b1;
            OP_SW:  cls_oh_o[C_SW]  = 1'b1;
            OP_BEQ: cls_oh_o[C_BEQ] = 1'b1;
            OP_BNE: cls_oh_o[C_BNE] = 1'b1;
            OP_J:   cls_oh_o[C_J]   = 1'b1;
            OP_JAL: cls_oh_o[C_JAL] = 1'b1;
            default: ;
        endcase
    end

    assign illegal_o = (cls_oh_o == '0);

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB(/ERR).
// In: clk, rst_n (sync, active low), opcode, func, zero, mem_ready.
// Out: datapath strobes/selects, instr_done, illegal, bus_err, state.
// Option MCC_MEM_TIMEOUT_EN: mem_ready wait timeout into sticky ERR.
module multi_cycle_controller
    import mcc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int STATE_W     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCW,
    output logic               IRW,
    output logic               MemR,
    output logic               MemW,
    output logic               IorD,
    output logic               RegW,
    output logic               ext,
    output logic [3:0]         ALUopcode,
    output logic [1:0]         sourceA,
    output logic [1:0]         sourceB,
    output logic [1:0]         toReg,
    output logic [1:0]         destReg,
    output logic [1:0]         jump,
    output logic               instr_done,
    output logic               illegal,
    output logic               bus_err,
    output logic [STATE_W-1:0] state
);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    cls_t             dec_cls;
    logic [CLS_N-1:0] dec_oh;
    logic             dec_ill;
    logic             tmo_hit;

    mcc_class_decoder u_dec (
        .opcode_i  (opcode),
        .func_i    (func),
        .cls_oh_o  (dec_oh),
        .illegal_o (dec_ill)
    );

    assign dec_cls = cls_from_onehot(dec_oh);

`ifdef MCC_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic             bus_err_q;

    always_comb begin
        waiting = ((state_q == S_FETCH) || (state_q == S_MEM))
                  && !mem_ready;
        cnt_d   = waiting ? cnt_q + CNT_W'(1) : '0;
        // cnt_q counts earlier waits; this cycle is wait number cnt_q+1
        tmo_hit = waiting && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_d == S_ERR) bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = MEM_TIMEOUT;
    assign tmo_hit    = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        PCW        = 1'b0;
        IRW        = 1'b0;
        MemR       = 1'b0;
        MemW       = 1'b0;
        IorD       = 1'b0;
        RegW       = 1'b0;
        ext        = 1'b0;
        ALUopcode  = ALU_ADD;
        sourceA    = SRCA_PC;
        sourceB    = SRCB_REG;
        toReg      = TR_ALU;
        destReg    = DR_RT;
        jump       = J_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemR    = 1'b1;
                sourceB = SRCB_FOUR;
                if (mem_ready) begin
                    IRW     = 1'b1;
                    PCW     = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                // speculative branch target: PC + (sext(imm) << 2)
                sourceB = SRCB_IMMS2;
                ext     = 1'b1;
                cls_d   = dec_cls;
                if (dec_ill) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    cls_d      = C_NOP;
                    state_d    = S_FETCH;
                end else if (dec_cls == C_NOP) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_RTYPE: begin
                        sourceA   = SRCA_REG;
                        ALUopcode = alu_op(opcode, func);
                        state_d   = S_WB;
                    end
                    C_SHIFT: begin
                        // variable shifts (func[2]) take amount from rs
                        sourceA   = func[2] ? SRCA_REG : SRCA_SHAMT;
                        ALUopcode = alu_op(opcode, func);
                        state_d   = S_WB;
                    end
                    C_ITYPE: begin
                        sourceA   = SRCA_REG;
                        sourceB   = SRCB_IMM;
                        ext       = !((opcode == OP_ANDI)
                                   || (opcode == OP_ORI)
                                   || (opcode == OP_XORI));
                        ALUopcode = alu_op(opcode, func);
                        state_d   = S_WB;
                    end
                    C_LW, C_SW: begin
                        sourceA = SRCA_REG;
                        sourceB = SRCB_IMM;
                        ext     = 1'b1;
                        state_d = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        sourceA    = SRCA_REG;
                        ALUopcode  = ALU_SUB;
                        ext        = 1'b1;
                        jump       = J_BR;
                        PCW        = (cls_q == C_BEQ) ? zero : !zero;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_J, C_JR, C_JAL, C_JALR: begin
                        PCW = 1'b1;
                        jump = ((cls_q == C_J) || (cls_q == C_JAL))
                               ? J_TGT : J_REG;
                        if ((cls_q == C_JAL) || (cls_q == C_JALR)) begin
                            RegW    = 1'b1;
                            toReg   = TR_PC;
                            destReg = (cls_q == C_JAL) ? DR_RA : DR_RD;
                        end
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                IorD = 1'b1;
                MemR = (cls_q == C_LW);
                MemW = (cls_q == C_SW);
                if (mem_ready) begin
                    if (cls_q == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                RegW       = 1'b1;
                toReg      = (cls_q == C_LW) ? TR_MEM : TR_ALU;
                destReg    = ((cls_q == C_RTYPE) || (cls_q == C_SHIFT))
                             ? DR_RD : DR_RT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // reset kills strobes at once so an in-flight access never commits
        if (!rst_n) begin
            PCW        = 1'b0;
            IRW        = 1'b0;
            MemR       = 1'b0;
            MemW       = 1'b0;
            RegW       = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-cycle expectations
// are queued by the stimulus and checked by an independent monitor.
module tb_multi_cycle_controller;
    import mcc_pkg::*;

`ifdef MCC_MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCW, IRW, MemR, MemW, IorD, RegW, ext;
    logic [3:0] ALUopcode;
    logic [1:0] sourceA, sourceB, toReg, destReg, jump;
    logic       instr_done, illegal, bus_err;
    logic [2:0] state;

    multi_cycle_controller #(.MEM_TIMEOUT(TMO), .STATE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func),
        .zero(zero), .mem_ready(mem_ready),
        .PCW(PCW), .IRW(IRW), .MemR(MemR), .MemW(MemW), .IorD(IorD),
        .RegW(RegW), .ext(ext), .ALUopcode(ALUopcode),
        .sourceA(sourceA), .sourceB(sourceB), .toReg(toReg),
        .destReg(destReg), .jump(jump), .instr_done(instr_done),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    // strobe word order: PCW IRW MemR MemW IorD RegW done illegal ext
    localparam logic [8:0] NONE  = 9'b000_000_000;
    localparam logic [8:0] F_RDY = 9'b111_000_000;
    localparam logic [8:0] F_WT  = 9'b001_000_000;
    localparam logic [8:0] DEC   = 9'b000_000_001;
    localparam logic [8:0] DEC_D = 9'b000_000_101;
    localparam logic [8:0] DEC_I = 9'b000_000_111;
    localparam logic [8:0] EX_E  = 9'b000_000_001;
    localparam logic [8:0] WBK   = 9'b000_001_100;
    localparam logic [8:0] M_RD  = 9'b001_010_000;
    localparam logic [8:0] M_WR  = 9'b000_110_000;
    localparam logic [8:0] M_WRD = 9'b000_110_100;
    localparam logic [8:0] BR_T  = 9'b100_000_101;
    localparam logic [8:0] BR_N  = 9'b000_000_101;
    localparam logic [8:0] JMP   = 9'b100_000_100;
    localparam logic [8:0] JAL   = 9'b100_001_100;
    localparam logic [8:0] RST_M = 9'b000_010_000;

    typedef struct packed {
        logic [2:0] st;
        logic [8:0] str;
        logic       be;
        logic       chk;
        logic [9:0] sel;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_be = 1'b0;

    function automatic logic [9:0] S(logic [3:0] a, logic [1:0] t,
                                     logic [1:0] d, logic [1:0] j);
        return {a, t, d, j};
    endfunction

    task automatic step(input logic rn, input logic [5:0] op,
                        input logic [5:0] fn, input logic z,
                        input logic mr, input state_t st,
                        input logic [8:0] str, input logic chk,
                        input logic [9:0] sel);
        exp_t e;
        rst_n = rn; opcode = op; func = fn; zero = z; mem_ready = mr;
        e.st = 3'(st); e.str = str; e.be = exp_be;
        e.chk = chk; e.sel = sel;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    int cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] a_str;
        logic [9:0] a_sel;
        if (q.size() > 0) begin
            e = q.pop_front();
            a_str = {PCW, IRW, MemR, MemW, IorD, RegW,
                     instr_done, illegal, ext};
            a_sel = {ALUopcode, toReg, destReg, jump};
            n_cmp++;
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL cyc%0d state got %0d want %0d",
                         cyc, state, e.st);
            end
            n_cmp++;
            if (a_str !== e.str) begin
                n_bad++;
                $display("FAIL cyc%0d strobes got %b want %b",
                         cyc, a_str, e.str);
            end
            n_cmp++;
            if (bus_err !== e.be) begin
                n_bad++;
                $display("FAIL cyc%0d bus_err got %b want %b",
                         cyc, bus_err, e.be);
            end
            if (e.chk) begin
                n_cmp++;
                if (a_sel !== e.sel) begin
                    n_bad++;
                    $display("FAIL cyc%0d sel got %h want %h",
                             cyc, a_sel, e.sel);
                end
            end
            n_cmp++;
            if ((32'(MemW) + 32'(RegW) + 32'(PCW) > 1)
                && !(RegW && PCW && !MemW)) begin
                n_bad++;
                $display("FAIL cyc%0d excl got %b%b%b want <=1",
                         cyc, MemW, RegW, PCW);
            end
            cyc++;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset held
        step(0, 6'h00, 6'h00, 0, 1, S_FETCH, NONE, 0, '0);
        // add
        step(1, OP_RTYPE, F_ADD, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, F_ADD, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_RTYPE, F_ADD, 0, 1, S_EXEC, NONE, 1,
             S(ALU_ADD, TR_ALU, DR_RT, J_ALU));
        step(1, OP_RTYPE, F_ADD, 0, 1, S_WB, WBK, 1,
             S(ALU_ADD, TR_ALU, DR_RD, J_ALU));
        // sub
        step(1, OP_RTYPE, F_SUB, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, F_SUB, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_RTYPE, F_SUB, 0, 1, S_EXEC, NONE, 1,
             S(ALU_SUB, TR_ALU, DR_RT, J_ALU));
        step(1, OP_RTYPE, F_SUB, 0, 1, S_WB, WBK, 0, '0);
        // lw, 3 wait cycles in MEM
        step(1, OP_LW, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_LW, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_LW, 6'h00, 0, 1, S_EXEC, EX_E, 0, '0);
        for (int i = 0; i < 3; i++)
            step(1, OP_LW, 6'h00, 0, 0, S_MEM, M_RD, 0, '0);
        step(1, OP_LW, 6'h00, 0, 1, S_MEM, M_RD, 0, '0);
        step(1, OP_LW, 6'h00, 0, 1, S_WB, WBK, 1,
             S(ALU_ADD, TR_MEM, DR_RT, J_ALU));
        // beq taken / not taken, bne taken
        step(1, OP_BEQ, 6'h00, 1, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_BEQ, 6'h00, 1, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_BEQ, 6'h00, 1, 1, S_EXEC, BR_T, 1,
             S(ALU_SUB, TR_ALU, DR_RT, J_BR));
        step(1, OP_BEQ, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_BEQ, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_BEQ, 6'h00, 0, 1, S_EXEC, BR_N, 0, '0);
        step(1, OP_BNE, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_BNE, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_BNE, 6'h00, 0, 1, S_EXEC, BR_T, 0, '0);
        // jal, jalr, jr, j
        step(1, OP_JAL, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_JAL, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_JAL, 6'h00, 0, 1, S_EXEC, JAL, 1,
             S(ALU_ADD, TR_PC, DR_RA, J_TGT));
        step(1, OP_RTYPE, F_JALR, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, F_JALR, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_RTYPE, F_JALR, 0, 1, S_EXEC, JAL, 1,
             S(ALU_ADD, TR_PC, DR_RD, J_REG));
        step(1, OP_RTYPE, F_JR, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, F_JR, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_RTYPE, F_JR, 0, 1, S_EXEC, JMP, 1,
             S(ALU_ADD, TR_ALU, DR_RT, J_REG));
        step(1, OP_J, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_J, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_J, 6'h00, 0, 1, S_EXEC, JMP, 1,
             S(ALU_ADD, TR_ALU, DR_RT, J_TGT));
        // illegal opcode, illegal func, nop
        step(1, 6'h3F, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, 6'h3F, 6'h00, 0, 1, S_DECODE, DEC_I, 0, '0);
        step(1, OP_RTYPE, 6'h3F, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, 6'h3F, 0, 1, S_DECODE, DEC_I, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 1, S_DECODE, DEC_D, 0, '0);
        // andi (zero-ext), addi (sign-ext)
        step(1, OP_ANDI, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_ANDI, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_ANDI, 6'h00, 0, 1, S_EXEC, NONE, 1,
             S(ALU_AND, TR_ALU, DR_RT, J_ALU));
        step(1, OP_ANDI, 6'h00, 0, 1, S_WB, WBK, 1,
             S(ALU_ADD, TR_ALU, DR_RT, J_ALU));
        step(1, OP_ADDI, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_ADDI, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_ADDI, 6'h00, 0, 1, S_EXEC, EX_E, 0, '0);
        step(1, OP_ADDI, 6'h00, 0, 1, S_WB, WBK, 0, '0);
        // fetch wait states then nop
        step(1, OP_RTYPE, F_NOP, 0, 0, S_FETCH, F_WT, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 0, S_FETCH, F_WT, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 1, S_DECODE, DEC_D, 0, '0);
        // sw, zero wait
        step(1, OP_SW, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_SW, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_SW, 6'h00, 0, 1, S_EXEC, EX_E, 0, '0);
        step(1, OP_SW, 6'h00, 0, 1, S_MEM, M_WRD, 0, '0);
        // sw interrupted by reset during a MEM wait
        step(1, OP_SW, 6'h00, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_SW, 6'h00, 0, 1, S_DECODE, DEC, 0, '0);
        step(1, OP_SW, 6'h00, 0, 1, S_EXEC, EX_E, 0, '0);
        step(1, OP_SW, 6'h00, 0, 0, S_MEM, M_WR, 0, '0);
        step(0, OP_SW, 6'h00, 0, 0, S_MEM, RST_M, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 1, S_FETCH, F_RDY, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 1, S_DECODE, DEC_D, 0, '0);
`ifdef MCC_MEM_TIMEOUT_EN
        for (int i = 0; i < TMO; i++)
            step(1, OP_RTYPE, F_NOP, 0, 0, S_FETCH, F_WT, 0, '0);
        exp_be = 1'b1;
        step(1, OP_RTYPE, F_NOP, 0, 0, S_ERR, NONE, 0, '0);
        step(1, OP_RTYPE, F_NOP, 0, 1, S_ERR, NONE, 0, '0);
        step(0, OP_RTYPE, F_NOP, 0, 1, S_ERR, NONE, 0, '0);
        exp_be = 1'b0;
        step(1, OP_RTYPE, F_NOP, 0, 1, S_FETCH, F_RDY, 0, '0);
`endif
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
